twiddle_gen_radix2: RTL
=======================

# twiddle_gen_radix2

Parametrised, streaming twiddle-factor generator for the multimode radix-2 FFT datapath. It supports any power-of-two size from 4 up to 2^MAX_LOG2N points from a single quarter-wave cosine table. For a requested size and stage, it emits the per-butterfly twiddles in butterfly order over a valid/ready stream. It sits beside the stage sequencer and feeds the complex multiplier in the butterfly pipeline.

## Interface
- WIDTH, 16: twiddle component width, signed Q(WIDTH-1).
- MAX_LOG2N, 6: log2 of the largest supported FFT size; MAX_N = 2^MAX_LOG2N and Q = MAX_N/4.
- clk  in  1  clock. Everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse. Accepted only when busy=0.
- cfg_log2n  in  $clog2(MAX_LOG2N+1)  log2 of FFT size N. Legal range is 2..MAX_LOG2N.
- cfg_stage  in  $clog2(MAX_LOG2N)  DIF stage s. Legal range is 0..cfg_log2n-1.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- busy  out  1  a sequence is in progress.
- tw_valid  out  1  output word valid.
- tw_ready  in  1  consumer accepts the word.
- tw_real  out  WIDTH  signed real part of W_N^k.
- tw_imag  out  WIDTH  signed imaginary part of W_N^k.
- tw_idx  out  MAX_LOG2N-1  butterfly index j.
- tw_last  out  1  high on the word with j = N/2-1.

## Operation
- **Start acceptance:** start && !busy with legal cfg latches N, s and clears j.
- **Rejection:** illegal cfg (log2n<2, log2n>MAX_LOG2N, or stage≥log2n) asserts cfg_err for one cycle. busy stays 0 and nothing is emitted.
- **Ignored starts:** start while busy=1 is ignored silently, with no cfg_err.
- **Sequence:** for j = 0..N/2-1, the block emits W_N^k = cos(2πk/N) − j·sin(2πk/N).
  - k = (j mod (N>>(s+1))) << s.
- **Address scaling:** kmax = k << (MAX_LOG2N − log2n), which is always < MAX_N/2.
- **Table:** C[m] = round(32767·cos(2πm/MAX_N)) for m = 0..Q, giving Q+1 entries. C[0]=32767 and C[Q]=0.
- **Quadrant fold:** q = kmax / Q and r = kmax mod Q.
  - q=0: real = C[r], imag = −C[Q−r].
  - q=1: real = −C[Q−r], imag = −C[r].
- **Negation:** negation never overflows, because |C| ≤ 32767.
- **Counter:** j advances only when a table lookup is issued into the pipeline. No index is skipped or repeated.
- **Reset values:** tw_valid=0, busy=0, cfg_err=0, tw_real=0, tw_imag=0, tw_idx=0, tw_last=0. Internal j and config are cleared.
- **Reset mid-sequence:** the sequence is aborted with no further words. A new start is accepted from the first cycle after rst deasserts.

## Timing
- **Pipeline:** two registered stages.
  - P1: address fold and ROM read.
  - P2: sign/swap and output register.
- **Pipeline advance:** the pipeline advances when en = !tw_valid || tw_ready. When en=0, both stages and j hold.
- **Latency:** start accepted in cycle T gives busy=1 at T+1 and first tw_valid at T+2.
- **Throughput:** with tw_ready held high, one word per cycle. N/2 words appear in cycles T+2..T+1+N/2.
- **Output stability:** while tw_valid && !tw_ready, tw_real, tw_imag, tw_idx and tw_last are held stable.
- **End of sequence:** busy falls the cycle after the handshake with tw_last=1. The next start is accepted in that cycle or later.
- **Overlap:** there is never any overlap between consecutive sequences.
- **Error timing:** cfg_err is asserted in cycle T+1 for a rejected start in cycle T.

## Structure
- **Package twiddle_pkg:**
  - the C[] table as a constant function of MAX_LOG2N and WIDTH;
  - the Q(WIDTH-1) one constant;
  - the legality check function for (log2n, stage).
- **Sub-module twiddle_qwave_rom:** the registered Q+1-entry lookup, parameterised by MAX_LOG2N and WIDTH.
- **Top level:** sequencer (idle/run FSM, j counter), address fold, output stage.

## Test plan
(Defaults: WIDTH=16, MAX_LOG2N=6.)
1. log2n=4, s=0, ready high gives 8 words at T+2..T+9.
   - j=0 is (32767, 0).
   - j=2 is (23170, −23170).
   - j=4 is (0, −32767).
   - j=7 is (−30273, −12540), with tw_last=1.
   - busy drops at T+10.
2. log2n=4, s=2 gives k alternating 0,4. Output alternates (32767, 0) and (0, −32767), four times each.
3. log2n=6, s=0.
   - j=8 gives (23170, −23170).
   - j=16 gives (0, −32767).
   - j=31 gives (−32609, −3212), with tw_last=1.
4. log2n=5, s=0: drop tw_ready for 3 cycles while j=3 is presented. The j=3 word is held unchanged, the next accepted word is j=4, and exactly 16 words are delivered.
5. Rejections.
   - start with log2n=7 gives a cfg_err pulse at T+1, busy=0 and no tw_valid.
   - start with log2n=4, s=4 gives the same response.
   - start while busy gives no effect.
6. Assert rst for one cycle after 3 handshakes: the next cycle shows tw_valid=0 and busy=0. A fresh start of log2n=3, s=0 then yields 4 words starting at j=0, (32767, 0).

Source files
------------

// File: rtl/twiddle_pkg.sv
// Shared types and elaboration-time helpers for the radix-2 twiddle generator:
// quarter-wave cosine coefficients and the (log2n, stage) legality check.
package twiddle_pkg;

    localparam real TW_PI = 3.14159265358979323846;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN
    } seq_state_t;

    function automatic int q_one(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // Entries past the quarter point are never addressed and read as zero.
    function automatic int qwave_coef(input int m, input int max_log2n, input int width);
        real x;
        if (m > (1 << (max_log2n - 2))) begin
            return 0;
        end
        x = real'(q_one(width)) * $cos(2.0 * TW_PI * real'(m) / real'(1 << max_log2n));
        return $rtoi(x + 0.5);
    endfunction

    function automatic logic cfg_legal(input int log2n, input int stage, input int max_log2n);
        return (log2n >= 2) && (log2n <= max_log2n) && (stage < log2n);
    endfunction

endpackage

// File: rtl/twiddle_qwave_rom.sv
// Registered dual-read quarter-wave cosine table, C[0..Q] with C[0]=one, C[Q]=0.
module twiddle_qwave_rom
    import twiddle_pkg::*;
#(
    parameter int MAX_LOG2N = 6,
    parameter int WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic [MAX_LOG2N-2:0]      addr_a,
    input  logic [MAX_LOG2N-2:0]      addr_b,
    output logic signed [WIDTH-1:0]   data_a,
    output logic signed [WIDTH-1:0]   data_b
);

    localparam int DEPTH = 1 << (MAX_LOG2N - 1);

    logic signed [WIDTH-1:0] coef [DEPTH];

    for (genvar m = 0; m < DEPTH; m++) begin : g_coef
        assign coef[m] = WIDTH'(qwave_coef(m, MAX_LOG2N, WIDTH));
    end

    always_ff @(posedge clk) begin
        if (en) begin
            data_a <= coef[addr_a];
            data_b <= coef[addr_b];
        end
    end

endmodule

// File: rtl/twiddle_gen_radix2.sv
// Streaming radix-2 DIF twiddle generator: sequencer, quadrant fold and a
// two-stage (ROM read, sign/swap) pipeline behind a valid/ready output.
//
// state    | meaning
// ST_IDLE  | no sequence; start is checked, j=0 is issued on acceptance
// ST_FEED  | issuing j = 1 .. N/2-1 into the pipeline
// ST_DRAIN | all lookups issued, waiting for the tw_last handshake
module twiddle_gen_radix2
    import twiddle_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MAX_LOG2N = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [$clog2(MAX_LOG2N+1)-1:0]     cfg_log2n,
    input  logic [$clog2(MAX_LOG2N)-1:0]       cfg_stage,
    output logic                               cfg_err,
    output logic                               busy,
    output logic                               tw_valid,
    input  logic                               tw_ready,
    output logic signed [WIDTH-1:0]            tw_real,
    output logic signed [WIDTH-1:0]            tw_imag,
    output logic [MAX_LOG2N-2:0]               tw_idx,
    output logic                               tw_last
);

    localparam int LW = $clog2(MAX_LOG2N + 1);
    localparam int AW = MAX_LOG2N - 1;
    localparam logic [AW-1:0] QADDR = AW'(1 << (MAX_LOG2N - 2));

    seq_state_t state, state_nx;

    logic [AW-1:0]           j_cnt, j_nx, issue_j;
    logic [LW-1:0]           log2n_q;
    logic [$clog2(MAX_LOG2N)-1:0] stage_q;
    logic                    en, accept, reject, issue;
    logic [AW-1:0]           jmask, last_j, kmax, addr_a, addr_b;
    logic                    v1, q1, last1;
    logic [AW-1:0]           idx1;
    logic signed [WIDTH-1:0] rom_a, rom_b;

    assign en   = !tw_valid || tw_ready;
    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        issue    = 1'b0;
        issue_j  = '0;
        j_nx     = j_cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_legal(int'(cfg_log2n), int'(cfg_stage), MAX_LOG2N)) begin
                        accept   = 1'b1;
                        issue    = 1'b1;
                        j_nx     = AW'(1);
                        state_nx = ST_FEED;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            ST_FEED: begin
                if (en) begin
                    issue   = 1'b1;
                    issue_j = j_cnt;
                    j_nx    = j_cnt + AW'(1);
                    if (j_cnt == last_j) begin
                        state_nx = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (tw_valid && tw_ready && tw_last) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // j=0 always folds to address 0, so the stale config on the start cycle is harmless.
    always_comb begin
        jmask  = ~({AW{1'b1}} << (log2n_q - LW'(stage_q) - LW'(1)));
        last_j = ~({AW{1'b1}} << (log2n_q - LW'(1)));
        kmax   = ((issue_j & jmask) << stage_q) << (LW'(MAX_LOG2N) - log2n_q);
        addr_a = {1'b0, kmax[AW-2:0]};
        addr_b = QADDR - addr_a;
    end

    twiddle_qwave_rom #(
        .MAX_LOG2N (MAX_LOG2N),
        .WIDTH     (WIDTH)
    ) u_rom (
        .clk    (clk),
        .en     (en),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .data_a (rom_a),
        .data_b (rom_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            j_cnt    <= '0;
            log2n_q  <= '0;
            stage_q  <= '0;
            cfg_err  <= 1'b0;
            v1       <= 1'b0;
            q1       <= 1'b0;
            idx1     <= '0;
            last1    <= 1'b0;
            tw_valid <= 1'b0;
            tw_real  <= '0;
            tw_imag  <= '0;
            tw_idx   <= '0;
            tw_last  <= 1'b0;
        end else begin
            cfg_err <= reject;
            j_cnt   <= j_nx;
            if (accept) begin
                log2n_q <= cfg_log2n;
                stage_q <= cfg_stage;
            end
            if (en) begin
                v1       <= issue;
                q1       <= kmax[AW-1];
                idx1     <= issue_j;
                last1    <= issue && (state == ST_FEED) && (issue_j == last_j);
                tw_valid <= v1;
                if (v1) begin
                    // Second quadrant: cos/sin swap roles and both parts go negative.
                    tw_real <= q1 ? -rom_b : rom_a;
                    tw_imag <= q1 ? -rom_a : -rom_b;
                    tw_idx  <= idx1;
                    tw_last <= last1;
                end
            end
        end
    end

endmodule
